traffic_light_ctrl_param: RTL and testbench
===========================================

// Module: traffic_light_ctrl_param
// PURPOSE
//  Two-way (NS/EW) intersection controller, parametrised successor to the fixed-timing controller.
//  Programmable phase durations, pedestrian request with minimum-green truncation, and night flash mode.
//  Sits between the intersection timing source (clk) and the lamp drivers; one instance per junction.
// PARAMETERS
//  CNT_W     8   width of phase elapsed counter; must hold max(GREEN_T,YELLOW_T,ALLRED_T,FLASH_T)-1
//  GREEN_T   15  green phase length, cycles (>=1)
//  YELLOW_T  3   yellow phase length, cycles (>=1)
//  ALLRED_T  3   all-red clearance length, cycles (>=1)
//  MIN_GREEN 5   minimum green served before ped truncation, cycles (1..GREEN_T)
//  FLASH_T   8   flash half-period, cycles (>=1)
// PORTS
//  clk       in   1  clock, all state on rising edge
//  rst_n     in   1  asynchronous active-low reset
//  ped_req   in   1  pedestrian button, sampled each cycle (pulse or level)
//  flash     in   1  night flash mode request, level
//  ns_g,ns_y,ns_r in/out: out 1 each  NS lamps
//  ew_g,ew_y,ew_r out 1 each  EW lamps
//  ped_walk  out  1  walk signal
//  phase     out  3  current state encoding (debug/status)
// BEHAVIOUR
//  States (phase): NSG=0 NSY=1 AR1=2 EWG=3 EWY=4 AR2=5 FLASH=6; 7 illegal -> AR2 next cycle.
//  Elapsed counter e: 0 on every state entry, +1 per cycle in-state; phase of length D occupies e=0..D-1.
//  Transitions (evaluated each cycle, take effect next edge):
//   NSG->NSY, EWG->EWY: e==GREEN_T-1, or (ped_pend && e>=MIN_GREEN-1).
//   NSY->AR1, EWY->AR2: e==YELLOW_T-1.
//   AR1->EWG, AR2->NSG: e==ALLRED_T-1 and flash==0; ->FLASH if flash==1 at that cycle.
//   FLASH->AR2: first cycle flash==0 is sampled; then normal AR2->NSG.
//  flash only honoured at all-red boundaries; never cuts a green or yellow.
//  Lamps: Moore decode of registered state, exactly one lamp per direction lit:
//   NSG: ns_g,ew_r  NSY: ns_y,ew_r  AR1/AR2: ns_r,ew_r  EWG: ns_r,ew_g  EWY: ns_r,ew_y
//   FLASH: ns_y=lamp_on, ew_r=lamp_on, all others 0.
//  lamp_on: 1 on FLASH entry; toggles when e==FLASH_T-1 (e then restarts at 0).
//  ped_pend: set when ped_req==1 in any non-FLASH state; cleared on entry to AR1/AR2, where its
//   value is copied to ped_srv; cleared on FLASH entry; ped_req during AR* re-arms for next cycle.
//  ped_walk = ped_srv while in AR1/AR2; 0 elsewhere. ped_srv cleared on AR* exit.
//  Reset (async, rst_n=0): state NSG, e=0, ped_pend=0, ped_srv=0, lamp_on=0;
//   outputs ns_g=1 ew_r=1, all other lamps 0, ped_walk=0, phase=0. Release: e counts from first edge.
//  Reset mid-phase aborts immediately; no phase completion.
//  Default normal cycle period = 2*(GREEN_T+YELLOW_T+ALLRED_T) = 42 cycles.
// TESTING
//  T1 reset: rst_n=0 async mid-cycle -> ns_g=1,ew_r=1,others 0,phase=0 without a clock edge.
//  T2 defaults, no inputs: NSG 15, NSY 3, AR1 3, EWG 15, EWY 3, AR2 3 cycles; NSG again at cycle 42.
//  T3 ped_req 1-cycle pulse at NSG e=1 -> NSY entered after exactly 5 NSG cycles; ped_walk=1 for
//   all 3 AR1 cycles; EWG then full 15 cycles.
//  T4 ped_req at NSG e=12 (>MIN_GREEN) -> NSY next cycle (NSG lasts 13); ped_req during AR1 ->
//   EWG truncated to 5 cycles.
//  T5 flash=1 raised during EWG -> EWG/EWY full length, AR2 3 cycles, FLASH: ns_y/ew_r on 8, off 8;
//   flash=0 -> AR2 (3 cycles, all red) -> NSG.
//  T6 rst_n pulse during EWY e=1 with ped_pend=1 -> NSG, ped_pend cleared, full 15-cycle NSG after release.

Source files
------------

// File: rtl/traffic_light_ctrl_param.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_param
//
// Two-way (NS/EW) intersection controller with programmable phase lengths,
// pedestrian request with minimum-green truncation and a night flash mode.
// The normal sequence is NSG -> NSY -> AR1 -> EWG -> EWY -> AR2 -> NSG.
// Flash mode is only entered or left at an all-red boundary, so a green or
// yellow phase is never cut short by it.
//
// Parameters
//   CNT_W     width of the phase elapsed counter
//   GREEN_T   green phase length in cycles
//   YELLOW_T  yellow phase length in cycles
//   ALLRED_T  all-red clearance length in cycles
//   MIN_GREEN minimum green served before a pedestrian request truncates it
//   FLASH_T   flash half-period in cycles
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   ped_req    pedestrian button, sampled every cycle (pulse or level)
//   flash      night flash mode request (level)
//   ns_g/y/r   north-south lamps
//   ew_g/y/r   east-west lamps
//   ped_walk   walk signal, lit during the all-red that serves a request
//   phase      current state encoding for debug/status
// ---------------------------------------------------------------------------
module traffic_light_ctrl_param #(
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 3,
    parameter int MIN_GREEN = 5,
    parameter int FLASH_T   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       flash,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_NSG   = 3'd0,
        ST_NSY   = 3'd1,
        ST_AR1   = 3'd2,
        ST_EWG   = 3'd3,
        ST_EWY   = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6,
        ST_BAD   = 3'd7
    } state_t;

    // Last elapsed-count value of each phase, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] e_q, e_d;
    logic             ped_pend_q, ped_pend_d;
    logic             ped_srv_q, ped_srv_d;
    logic             lamp_on_q, lamp_on_d;

    logic             pend_now;
    logic             state_change;
    logic             ar_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_NSG;
            e_q        <= '0;
            ped_pend_q <= 1'b0;
            ped_srv_q  <= 1'b0;
            lamp_on_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            ped_pend_q <= ped_pend_d;
            ped_srv_q  <= ped_srv_d;
            lamp_on_q  <= lamp_on_d;
        end
    end

    // Next-state, elapsed counter, pedestrian bookkeeping and flash lamp.
    // A request seen this very cycle counts as pending so that a press late
    // in green (past the minimum) ends the green at the next edge.
    always_comb begin
        state_d      = state_q;
        e_d          = e_q + CNT_ONE;
        ped_pend_d   = ped_pend_q;
        ped_srv_d    = ped_srv_q;
        lamp_on_d    = lamp_on_q;
        pend_now     = ped_pend_q | (ped_req & (state_q != ST_FLASH));
        state_change = 1'b0;
        ar_next      = 1'b0;

        case (state_q)
            ST_NSG: begin
                if ((e_q == GREEN_LAST) || (pend_now && (e_q >= MIN_LAST))) begin
                    state_d = ST_NSY;
                end
            end
            ST_NSY: begin
                if (e_q == YELLOW_LAST) begin
                    state_d = ST_AR1;
                end
            end
            ST_AR1: begin
                if (e_q == ALLRED_LAST) begin
                    state_d = flash ? ST_FLASH : ST_EWG;
                end
            end
            ST_EWG: begin
                if ((e_q == GREEN_LAST) || (pend_now && (e_q >= MIN_LAST))) begin
                    state_d = ST_EWY;
                end
            end
            ST_EWY: begin
                if (e_q == YELLOW_LAST) begin
                    state_d = ST_AR2;
                end
            end
            ST_AR2: begin
                if (e_q == ALLRED_LAST) begin
                    state_d = flash ? ST_FLASH : ST_NSG;
                end
            end
            ST_FLASH: begin
                if (!flash) begin
                    state_d = ST_AR2;
                end
            end
            default: begin
                state_d = ST_AR2;
            end
        endcase

        state_change = (state_d != state_q);
        ar_next      = (state_d == ST_AR1) || (state_d == ST_AR2);

        // Every state entry restarts the counter; in flash it also wraps
        // each half-period, which is when the flashing lamp toggles.
        if (state_change) begin
            e_d = '0;
        end else if ((state_q == ST_FLASH) && (e_q == FLASH_LAST)) begin
            e_d       = '0;
            lamp_on_d = ~lamp_on_q;
        end

        if (state_change && (state_d == ST_FLASH)) begin
            lamp_on_d = 1'b1;
        end

        // The pending request is handed over to the all-red that follows,
        // and requests made during that all-red queue for the next one.
        if (state_d == ST_FLASH) begin
            ped_pend_d = 1'b0;
            ped_srv_d  = 1'b0;
        end else if (state_change && ar_next) begin
            ped_srv_d  = pend_now;
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = pend_now;
            if (!ar_next) begin
                ped_srv_d = 1'b0;
            end
        end
    end

    // Moore lamp decode of the registered state.
    always_comb begin
        ns_g     = 1'b0;
        ns_y     = 1'b0;
        ns_r     = 1'b0;
        ew_g     = 1'b0;
        ew_y     = 1'b0;
        ew_r     = 1'b0;
        ped_walk = 1'b0;
        phase    = state_q;

        case (state_q)
            ST_NSG: begin
                ns_g = 1'b1;
                ew_r = 1'b1;
            end
            ST_NSY: begin
                ns_y = 1'b1;
                ew_r = 1'b1;
            end
            ST_AR1, ST_AR2: begin
                ns_r     = 1'b1;
                ew_r     = 1'b1;
                ped_walk = ped_srv_q;
            end
            ST_EWG: begin
                ns_r = 1'b1;
                ew_g = 1'b1;
            end
            ST_EWY: begin
                ns_r = 1'b1;
                ew_y = 1'b1;
            end
            ST_FLASH: begin
                ns_y = lamp_on_q;
                ew_r = lamp_on_q;
            end
            default: begin
                ns_r = 1'b1;
                ew_r = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl_param
//
// Self-checking bench for traffic_light_ctrl_param with default parameters.
// A scripted vector table walks the normal cycle and the pedestrian cases,
// hand-written sequences cover async reset, reset with a pending request and
// flash mode, and a randomized run is compared cycle by cycle against a
// phase/age reference model.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl_param;

    localparam int CNT_W     = 8;
    localparam int GREEN_T   = 15;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 3;
    localparam int MIN_GREEN = 5;
    localparam int FLASH_T   = 8;

    localparam int P_NSG   = 0;
    localparam int P_NSY   = 1;
    localparam int P_AR1   = 2;
    localparam int P_EWG   = 3;
    localparam int P_EWY   = 4;
    localparam int P_AR2   = 5;
    localparam int P_FLASH = 6;

    logic       clk;
    logic       rst_n;
    logic       ped_req;
    logic       flash;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
    logic       ped_walk;
    logic [2:0] phase;

    int total;
    int bad;

    traffic_light_ctrl_param #(
        .CNT_W    (CNT_W),
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .MIN_GREEN(MIN_GREEN),
        .FLASH_T  (FLASH_T)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ped_req (ped_req),
        .flash   (flash),
        .ns_g    (ns_g),
        .ns_y    (ns_y),
        .ns_r    (ns_r),
        .ew_g    (ew_g),
        .ew_y    (ew_y),
        .ew_r    (ew_r),
        .ped_walk(ped_walk),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r,ped_walk,phase}
    // straight from the lamp table.
    function automatic logic [9:0] expVec(input int ph, input logic walk, input logic lamp);
        logic [5:0] l;
        case (ph)
            P_NSG:        l = 6'b100_001;
            P_NSY:        l = 6'b010_001;
            P_AR1, P_AR2: l = 6'b001_001;
            P_EWG:        l = 6'b001_100;
            P_EWY:        l = 6'b001_010;
            P_FLASH:      l = {1'b0, lamp, 1'b0, 1'b0, 1'b0, lamp};
            default:      l = 6'b001_001;
        endcase
        return {l, walk, 3'(ph)};
    endfunction

    task automatic applyStimulus(input logic p, input logic f);
        ped_req = p;
        flash   = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] want);
        logic [9:0] got;
        got = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk, phase};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%b want=%b (t=%0t)", name, got, want, $time);
        end
    endtask

    // Checks that the outputs hold the given value for exactly n samples
    // starting now; the caller's next check catches an overstay.
    task automatic holdCheck(input string name, input logic [9:0] want, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(name, want);
            tick();
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: phase index plus cycles spent in it.
    // ---------------------------------------------------------------
    int   m_ph;
    int   m_age;
    logic m_pend;
    logic m_srv;
    int   dur [6];

    task automatic modelReset();
        m_ph   = P_NSG;
        m_age  = 0;
        m_pend = 1'b0;
        m_srv  = 1'b0;
    endtask

    task automatic modelStep(input logic p, input logic f);
        int   nxt;
        logic req;
        logic is_ar_n;
        nxt = m_ph;
        req = p && (m_ph != P_FLASH);
        if (m_ph == P_FLASH) begin
            if (!f) nxt = P_AR2;
        end else if ((m_ph == P_NSG || m_ph == P_EWG) && (req || m_pend) && (m_age >= MIN_GREEN - 1)) begin
            nxt = m_ph + 1;
        end else if (m_age == dur[m_ph] - 1) begin
            if ((m_ph == P_AR1 || m_ph == P_AR2) && f) nxt = P_FLASH;
            else nxt = (m_ph + 1) % 6;
        end
        is_ar_n = (nxt == P_AR1) || (nxt == P_AR2);
        if (nxt == P_FLASH) begin
            m_pend = 1'b0;
            m_srv  = 1'b0;
        end else if (nxt != m_ph && is_ar_n) begin
            m_srv  = m_pend | req;
            m_pend = 1'b0;
        end else begin
            m_pend = m_pend | req;
            if (!is_ar_n) m_srv = 1'b0;
        end
        m_age = (nxt != m_ph) ? 0 : m_age + 1;
        m_ph  = nxt;
    endtask

    function automatic logic [9:0] modelVec();
        logic walk;
        logic lamp;
        walk = (m_ph == P_AR1 || m_ph == P_AR2) && m_srv;
        lamp = (m_ph == P_FLASH) && (((m_age / FLASH_T) % 2) == 0);
        return expVec(m_ph, walk, lamp);
    endfunction

    // ---------------------------------------------------------------
    // Vector table: inputs held for 'cycles' edges, then outputs checked.
    // ---------------------------------------------------------------
    typedef struct {
        logic ped;
        logic flsh;
        int   cycles;
        int   ph;
        logic walk;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic p, input logic f, input int n, input int ph, input logic w);
        vec_t v;
        v.ped    = p;
        v.flsh   = f;
        v.cycles = n;
        v.ph     = ph;
        v.walk   = w;
        vecs.push_back(v);
    endtask

    initial begin
        logic ped_r;
        logic fl_r;
        logic rst_r;

        total = 0;
        bad   = 0;
        dur[0] = GREEN_T;  dur[1] = YELLOW_T; dur[2] = ALLRED_T;
        dur[3] = GREEN_T;  dur[4] = YELLOW_T; dur[5] = ALLRED_T;

        // Default cycle, 42 cycles back to NSG.
        addVec(0, 0, 14, P_NSG, 0);
        addVec(0, 0, 1,  P_NSY, 0);
        addVec(0, 0, 2,  P_NSY, 0);
        addVec(0, 0, 1,  P_AR1, 0);
        addVec(0, 0, 2,  P_AR1, 0);
        addVec(0, 0, 1,  P_EWG, 0);
        addVec(0, 0, 14, P_EWG, 0);
        addVec(0, 0, 1,  P_EWY, 0);
        addVec(0, 0, 2,  P_EWY, 0);
        addVec(0, 0, 1,  P_AR2, 0);
        addVec(0, 0, 2,  P_AR2, 0);
        addVec(0, 0, 1,  P_NSG, 0);
        // Pulse at NSG e=1: green truncated to MIN_GREEN, walk through AR1.
        addVec(0, 0, 1,  P_NSG, 0);
        addVec(1, 0, 1,  P_NSG, 0);
        addVec(0, 0, 2,  P_NSG, 0);
        addVec(0, 0, 1,  P_NSY, 0);
        addVec(0, 0, 3,  P_AR1, 1);
        addVec(0, 0, 2,  P_AR1, 1);
        addVec(0, 0, 1,  P_EWG, 0);
        addVec(0, 0, 14, P_EWG, 0);
        addVec(0, 0, 1,  P_EWY, 0);
        addVec(0, 0, 3,  P_AR2, 0);
        addVec(0, 0, 3,  P_NSG, 0);
        // Press at NSG e=12 ends green at once; press in AR1 truncates EWG.
        addVec(0, 0, 12, P_NSG, 0);
        addVec(1, 0, 1,  P_NSY, 0);
        addVec(0, 0, 3,  P_AR1, 1);
        addVec(1, 0, 1,  P_AR1, 1);
        addVec(0, 0, 1,  P_AR1, 1);
        addVec(0, 0, 1,  P_EWG, 0);
        addVec(0, 0, 4,  P_EWG, 0);
        addVec(0, 0, 1,  P_EWY, 0);
        addVec(0, 0, 3,  P_AR2, 1);
        addVec(0, 0, 2,  P_AR2, 1);
        addVec(0, 0, 1,  P_NSG, 0);
        addVec(0, 0, 14, P_NSG, 0);
        addVec(0, 0, 1,  P_NSY, 0);

        // Asynchronous reset with no clock edge.
        applyStimulus(0, 0);
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_init", expVec(P_NSG, 0, 0));
        tick();
        tick();
        checkOutput("reset_held", expVec(P_NSG, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ped, vecs[i].flsh);
            repeat (vecs[i].cycles) tick();
            checkOutput($sformatf("vec%0d", i), expVec(vecs[i].ph, vecs[i].walk, 1'b0));
        end
        applyStimulus(0, 0);

        // Mid-cycle async reset during NSY.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_mid", expVec(P_NSG, 0, 0));
        tick();
        checkOutput("async_hold", expVec(P_NSG, 0, 0));
        rst_n = 1'b1;

        // Reset during EWY with a request pending clears it.
        holdCheck("t6_nsg", expVec(P_NSG, 0, 0), 15);
        holdCheck("t6_nsy", expVec(P_NSY, 0, 0), 3);
        holdCheck("t6_ar1", expVec(P_AR1, 0, 0), 3);
        applyStimulus(1, 0);
        holdCheck("t6_ewg_req", expVec(P_EWG, 0, 0), 1);
        applyStimulus(0, 0);
        holdCheck("t6_ewg", expVec(P_EWG, 0, 0), 4);
        holdCheck("t6_ewy", expVec(P_EWY, 0, 0), 1);
        checkOutput("t6_ewy_e1", expVec(P_EWY, 0, 0));
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset", expVec(P_NSG, 0, 0));
        tick();
        rst_n = 1'b1;
        holdCheck("t6_nsg_full", expVec(P_NSG, 0, 0), 15);
        holdCheck("t6_nsy2", expVec(P_NSY, 0, 0), 3);
        holdCheck("t6_ar1_nowalk", expVec(P_AR1, 0, 0), 3);

        // Flash requested in EWG, honoured only at the next all-red.
        holdCheck("t5_ewg_a", expVec(P_EWG, 0, 0), 2);
        applyStimulus(0, 1);
        holdCheck("t5_ewg_b", expVec(P_EWG, 0, 0), 13);
        holdCheck("t5_ewy", expVec(P_EWY, 0, 0), 3);
        holdCheck("t5_ar2", expVec(P_AR2, 0, 0), 3);
        holdCheck("t5_fl_on", expVec(P_FLASH, 0, 1), 8);
        holdCheck("t5_fl_off", expVec(P_FLASH, 0, 0), 8);
        applyStimulus(1, 1);
        holdCheck("t5_fl_on2", expVec(P_FLASH, 0, 1), 3);
        applyStimulus(0, 0);
        holdCheck("t5_fl_exit", expVec(P_FLASH, 0, 1), 1);
        holdCheck("t5_ar2_exit", expVec(P_AR2, 0, 0), 3);
        holdCheck("t5_nsg", expVec(P_NSG, 0, 0), 15);
        checkOutput("t5_nsy", expVec(P_NSY, 0, 0));

        // Randomized run against the reference model.
        rst_n = 1'b0;
        tick();
        modelReset();
        checkOutput("rand_reset", modelVec());
        rst_n = 1'b1;
        fl_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) fl_r = ~fl_r;
            ped_r = ($urandom_range(0, 9) == 0);
            rst_r = ($urandom_range(0, 599) != 0);
            applyStimulus(ped_r, fl_r);
            rst_n = rst_r;
            if (!rst_r) modelReset();
            else modelStep(ped_r, fl_r);
            tick();
            checkOutput("rand", modelVec());
        end
        rst_n = 1'b1;
        applyStimulus(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
